// File: rtl/ysyx_23060236_clint_slave.sv
// CLINT read-only AXI4-Lite responder: free-running 64-bit mtime with a
// prescaler, one R beat per accepted AR, and a high-word shadow so that a
// low-then-high read pair observes one consistent 64-bit sample.
module ysyx_23060236_clint_slave #(
    parameter logic [3:0]  TICK_DIV  = 4'd1,
    parameter logic [1:0]  RESP_LAT  = 2'd0,
    parameter logic [63:0] MTIME_RST = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    // A divider of zero behaves like a divider of one.
    localparam logic [3:0] LP_DIV      = (TICK_DIV == 4'd0) ? 4'd1 : TICK_DIV;
    localparam logic [3:0] LP_DIV_LAST = LP_DIV - 4'd1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [63:0] r_mtime;
    logic [3:0]  r_presc;
    logic [31:0] r_shadowHi;
    logic        r_shadowVld;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic        w_arHs;
    logic [31:0] w_decData;
    logic [1:0]  w_decResp;
    logic        w_loHit;
    logic        w_hiHit;
    logic        w_unusedAddrHi;

    // Only the 64 KiB window offset is decoded; the upper address bits are
    // already resolved by the crossbar.
    assign w_unusedAddrHi = ^araddr[31:16];

    assign arready = (r_state == ST_IDLE);
    assign rvalid  = (r_state == ST_RESP);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign w_arHs  = arvalid && (r_state == ST_IDLE);

    // Timer: prescaler wraps at the divider and bumps mtime; never stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_presc <= 4'd0;
            r_mtime <= MTIME_RST;
        end else if (r_presc == LP_DIV_LAST) begin
            r_presc <= 4'd0;
            r_mtime <= r_mtime + 64'd1;
        end else begin
            r_presc <= r_presc + 4'd1;
        end
    end

    // Address decode against the live mtime, used only at the AR handshake.
    always_comb begin
        w_decData = 32'd0;
        w_decResp = RESP_DECERR;
        w_loHit   = 1'b0;
        w_hiHit   = 1'b0;
        if (araddr[1:0] != 2'b00) begin
            w_decResp = RESP_SLVERR;
        end else begin
            case (araddr[15:0])
                16'h0000: w_decResp = RESP_OKAY;
                16'hBFF8: begin
                    w_decData = r_mtime[31:0];
                    w_decResp = RESP_OKAY;
                    w_loHit   = 1'b1;
                end
                16'hBFFC: begin
                    w_decData = r_shadowVld ? r_shadowHi : r_mtime[63:32];
                    w_decResp = RESP_OKAY;
                    w_hiHit   = 1'b1;
                end
                default: w_decResp = RESP_DECERR;
            endcase
        end
    end

    // Shadow: a low read captures the matching high word, a high read consumes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadowHi  <= 32'd0;
            r_shadowVld <= 1'b0;
        end else if (w_arHs && w_loHit) begin
            r_shadowHi  <= r_mtime[63:32];
            r_shadowVld <= 1'b1;
        end else if (w_arHs && w_hiHit) begin
            r_shadowVld <= 1'b0;
        end
    end

    // Read FSM: accept in IDLE, optional WAIT delay, hold the beat in RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_rdata <= 32'd0;
            r_rresp <= RESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arHs) begin
                        r_rdata <= w_decData;
                        r_rresp <= w_decResp;
                        if (RESP_LAT != 2'd0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= RESP_LAT;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
